adc_sample_sequencer: RTL and testbench
=======================================

# adc_sample_sequencer

Programmable sample scheduler and conversion sequencer for the ADC front end of the configurable modulator. It generates the sample-rate tick from the 50 MHz system clock using a run-time divisor, drives a one-shot start/done handshake to the ADC interface, and latches each result. Each result goes to the modulator datapath with a step index of 0 to STEPS-1, so that one modulation period spans STEPS samples.

## Interface
Parameters:
- DIV_W, 12, divisor counter width
- DATA_W, 12, ADC sample width
- STEPS, 25, samples per modulation period (step index wraps at STEPS)
- DEFAULT_DIV, 4000, divisor loaded at reset (50 MHz / 4000 = 12.5 kHz sample tick)
- MIN_DIV, 4, smallest accepted divisor; smaller requests are clamped up

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; one clock domain; synchronous, active-high
- enable  in  1  run sample tick generation
- cfg_div  in  DIV_W  requested divisor (tick period in clk cycles)
- cfg_load  in  1  one-cycle strobe capturing cfg_div into shadow register
- adc_start  out  1  one-cycle conversion start pulse to ADC interface
- adc_done  in  1  one-cycle conversion-complete pulse, adc_data valid same cycle
- adc_data  in  DATA_W  conversion result
- sample_data  out  DATA_W  last captured sample
- sample_valid  out  1  one-cycle strobe, sample_data/step_idx valid
- step_idx  out  5  index of sample presented with sample_valid, 0..STEPS-1
- cycle_start  out  1  high with sample_valid when step_idx == 0
- overrun  out  1  sticky: tick arrived while a conversion was in flight (macro-gated, see Configuration)

## Operation
- Divisor counter `cnt` counts 0..div_act-1 while enable=1. It wraps to 0 and raises an internal `tick` when cnt == div_act-1. With enable=0, `cnt` is held at 0 and no tick is produced.
- Shadow register: cfg_load stores max(cfg_div, MIN_DIV) into div_shadow.
  - div_act takes div_shadow on the wrap cycle, so the period in progress completes at the old value.
  - It also takes div_shadow on any cycle with enable=0.
- FSM states IDLE, START, WAIT, CAPTURE:
  - IDLE: on tick, go to START.
  - START: adc_start=1 (Moore output); go to WAIT unconditionally.
  - WAIT: on adc_done, register adc_data into the capture register and go to CAPTURE. Otherwise stay.
  - CAPTURE: sample_valid=1, sample_data=capture register, cycle_start=(step_idx==0). Next cycle: step_idx increments with wrap STEPS-1 -> 0, and the FSM returns to IDLE.
- A tick occurring in START, WAIT or CAPTURE is dropped and does not queue. The in-flight conversion proceeds unaffected.
- adc_done in IDLE/START/CAPTURE is ignored.
- Deasserting enable does not abort an in-flight conversion. The FSM completes it and stays in IDLE.
- Reset values:
  - cnt=0, div_act=div_shadow=DEFAULT_DIV, FSM=IDLE
  - step_idx=0, sample_data=0
  - adc_start=0, sample_valid=0, cycle_start=0, overrun=0
- Reset asserted in any state returns to IDLE on the next edge. A pending conversion is abandoned, and a later adc_done is ignored.

## Timing
- Tick at edge T (cnt == div_act-1) -> adc_start high for exactly cycle T+1 -> WAIT from T+2.
- adc_done sampled high in cycle D (D >= T+2) -> sample_valid high in cycle D+1 with the captured data -> step_idx updates at D+2.
- Minimum tick-to-valid latency is 3 cycles. A conversion must complete within div_act-3 cycles to avoid overrun.
- cfg_load on the same cycle as the wrap: the new value is used for the period starting after that wrap only if it was loaded strictly earlier; a same-cycle load takes effect at the following wrap.
- adc_start and sample_valid are never high in the same cycle, and each pulses for exactly one cycle.

## Configuration
- ADC_OVERRUN_EN defined:
  - overrun is set when a tick is dropped because FSM != IDLE.
  - It is cleared only by rst or cfg_load.
- ADC_OVERRUN_EN undefined:
  - overrun is tied to 0 and the detect logic is removed.
  - Dropped ticks are still dropped silently.

## Test plan
- Reset, enable=1, default divisor, adc_done 5 cycles after every adc_start -> adc_start pulses 4000 cycles apart, and sample_valid follows each by 6 cycles.
- cfg_div=10 with cfg_load, adc_done 2 cycles after start -> after the current period ends, ticks are spaced 10 cycles apart, and step_idx runs 0..24 then back to 0, with cycle_start exactly on step 0.
- cfg_div=2 with cfg_load -> div_act=4, so ticks come every 4 cycles.
- div=10, adc_done held off 15 cycles -> one tick dropped, no second adc_start during WAIT, overrun=1 (0 with ADC_OVERRUN_EN undefined), and a following cfg_load clears it.
- Assert rst for one cycle while in WAIT, then pulse adc_done -> no sample_valid, step_idx=0, and the next tick starts a fresh conversion at the DEFAULT_DIV period.
- Drop enable during WAIT, then give adc_done -> sample_valid is still emitted, and no further adc_start occurs while enable=0.

Source files
------------

// File: rtl/adc_sample_sequencer_if.sv
// adc_sample_sequencer_if: control, ADC handshake and sample-output bundle of the sample sequencer
//   enable       run sample tick generation
//   cfg_div      requested divisor (tick period in clk cycles)
//   cfg_load     one-cycle strobe capturing cfg_div
//   adc_start    one-cycle conversion start pulse
//   adc_done     one-cycle conversion-complete pulse, adc_data valid same cycle
//   adc_data     conversion result
//   sample_data  last captured sample
//   sample_valid one-cycle strobe, sample_data/step_idx valid
//   step_idx     index of the presented sample, 0..STEPS-1
//   cycle_start  high with sample_valid when step_idx == 0
//   overrun      sticky dropped-tick flag
// modport master: the controller/ADC side; modport slave: the sequencer.
interface adc_sample_sequencer_if #(
    parameter int DIV_W  = 12,
    parameter int DATA_W = 12
);
    logic              enable;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_load;
    logic              adc_start;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic [4:0]        step_idx;
    logic              cycle_start;
    logic              overrun;

    modport master (
        output enable, cfg_div, cfg_load, adc_done, adc_data,
        input  adc_start, sample_data, sample_valid, step_idx, cycle_start, overrun
    );

    modport slave (
        input  enable, cfg_div, cfg_load, adc_done, adc_data,
        output adc_start, sample_data, sample_valid, step_idx, cycle_start, overrun
    );
endinterface

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: sample-rate tick generator and one-shot ADC conversion sequencer
//   clk  system clock (50 MHz)
//   rst  synchronous active-high reset
//   bus  adc_sample_sequencer_if.slave: enable/cfg_div/cfg_load in, adc_start out,
//        adc_done/adc_data in, sample_data/sample_valid/step_idx/cycle_start/overrun out
// Optional feature: define ADC_OVERRUN_EN to build the sticky overrun detector;
// otherwise overrun is tied low and dropped ticks are discarded silently.
module adc_sample_sequencer #(
    parameter int DIV_W       = 12,
    parameter int DATA_W      = 12,
    parameter int STEPS       = 25,
    parameter int DEFAULT_DIV = 4000,
    parameter int MIN_DIV     = 4
) (
    input logic                    clk,
    input logic                    rst,
    adc_sample_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_CAPTURE} state_t;

    state_t            r_state;
    logic [DIV_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  r_div_act;
    logic [DIV_W-1:0]  r_div_shadow;
    logic [DATA_W-1:0] r_sample_data;
    logic [4:0]        r_step;
    logic              r_adc_start;
    logic              r_sample_valid;
    logic              r_cycle_start;
    logic              w_tick;
    logic              w_reload;
    logic [DIV_W-1:0]  w_div_req;

    assign w_tick    = bus.enable && (r_cnt == r_div_act - DIV_W'(1));
    // div_act only changes at a period boundary or while stopped, so cnt never exceeds it
    assign w_reload  = w_tick || !bus.enable;
    assign w_div_req = (bus.cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.cfg_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_div_act    <= DIV_W'(DEFAULT_DIV);
            r_div_shadow <= DIV_W'(DEFAULT_DIV);
        end else begin
            r_cnt <= w_reload ? '0 : r_cnt + DIV_W'(1);
            // reads the pre-load shadow, so a load on the wrap cycle waits one more period
            if (w_reload)
                r_div_act <= r_div_shadow;
            if (bus.cfg_load)
                r_div_shadow <= w_div_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_adc_start    <= 1'b0;
            r_sample_valid <= 1'b0;
            r_cycle_start  <= 1'b0;
            r_sample_data  <= '0;
            r_step         <= '0;
        end else begin
            r_adc_start    <= 1'b0;
            r_sample_valid <= 1'b0;
            r_cycle_start  <= 1'b0;
            case (r_state)
                S_IDLE: if (w_tick) begin
                    r_state     <= S_START;
                    r_adc_start <= 1'b1;
                end
                S_START: r_state <= S_WAIT;
                S_WAIT: if (bus.adc_done) begin
                    r_state        <= S_CAPTURE;
                    r_sample_data  <= bus.adc_data;
                    r_sample_valid <= 1'b1;
                    r_cycle_start  <= (r_step == '0);
                end
                S_CAPTURE: begin
                    r_state <= S_IDLE;
                    r_step  <= (r_step == 5'(STEPS - 1)) ? '0 : r_step + 5'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ADC_OVERRUN_EN
    logic r_overrun;
    always_ff @(posedge clk) begin
        if (rst)
            r_overrun <= 1'b0;
        else
            r_overrun <= (w_tick && r_state != S_IDLE) || (r_overrun && !bus.cfg_load);
    end
    assign bus.overrun = r_overrun;
`else
    assign bus.overrun = 1'b0;
`endif

    assign bus.adc_start    = r_adc_start;
    assign bus.sample_valid = r_sample_valid;
    assign bus.cycle_start  = r_cycle_start;
    assign bus.sample_data  = r_sample_data;
    assign bus.step_idx     = r_step;
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer: scoreboard bench for adc_sample_sequencer (tick spacing, handshake, step index, overrun, reset abort)
module tb_adc_sample_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_sample_sequencer_if bus ();
    adc_sample_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef ADC_OVERRUN_EN
    localparam int OVR = 1;
`else
    localparam int OVR = 0;
`endif

    typedef struct {
        logic [11:0] d;
        logic [4:0]  s;
        logic        cs;
        int          c;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          delay = 5;
    int          pend = 0;
    int          m_step = 0;
    bit          abort = 0;
    bit          prev_start = 0;
    logic [11:0] rdata = '0;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model answers each adc_start after `delay` cycles; the expected sample is queued then
    always @(negedge clk) begin
        exp_t e;
        bus.adc_done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.adc_done = 1'b1;
                bus.adc_data = rdata;
                if (!abort) begin
                    q.push_back('{rdata, 5'(m_step), m_step == 0, cyc + 1});
                    m_step = (m_step == 24) ? 0 : m_step + 1;
                end
            end
        end
        if (bus.adc_start) begin
            chk("start_width", prev_start, 0);
            chk("start_valid_overlap", bus.sample_valid, 0);
            pend  = delay;
            rdata = 12'($urandom_range(0, 4095));
        end
        if (bus.sample_valid) begin
            chk("valid_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("data", bus.sample_data, e.d);
                chk("step", bus.step_idx, e.s);
                chk("cycle_start", bus.cycle_start, e.cs);
                chk("valid_cycle", cyc, e.c);
            end
        end
        prev_start = bus.adc_start;
    end

    task automatic wait_start(input string tag, input int lim, output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.adc_start && n < lim);
        chk({tag, "_start_seen"}, bus.adc_start, 1);
        t = cyc;
    endtask

    task automatic load(input int div, input int d);
        @(negedge clk);
        delay        = d;
        bus.cfg_div  = 12'(div);
        bus.cfg_load = 1'b1;
        @(negedge clk);
        bus.cfg_load = 1'b0;
    endtask

    initial begin
        int t0, t, ts, s, v;
        bus.enable   = 1'b0;
        bus.cfg_div  = '0;
        bus.cfg_load = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_adc_start", bus.adc_start, 0);
        chk("rst_sample_valid", bus.sample_valid, 0);
        chk("rst_cycle_start", bus.cycle_start, 0);
        chk("rst_sample_data", bus.sample_data, 0);
        chk("rst_step_idx", bus.step_idx, 0);
        chk("rst_overrun", bus.overrun, 0);
        rst = 1'b0;
        bus.enable = 1'b1;

        wait_start("p1a", 5000, t0);
        wait_start("p1b", 5000, t);
        chk("period_default", t - t0, 4000);
        t0 = t;

        load(10, 2);
        wait_start("p2a", 5000, t);
        chk("period_before_reload", t - t0, 4000);
        t0 = t;
        for (int i = 0; i < 27; i++) begin
            wait_start("p2", 50, t);
            chk("period_10", t - t0, 10);
            t0 = t;
        end

        load(2, 1);
        wait_start("p3a", 50, t);
        chk("period_10_tail", t - t0, 10);
        t0 = t;
        for (int i = 0; i < 6; i++) begin
            wait_start("p3", 50, t);
            chk("period_clamped_4", t - t0, 4);
            t0 = t;
        end

        load(10, 15);
        wait_start("p4a", 50, t);
        chk("period_4_tail", t - t0, 4);
        t0 = t;
        s = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.adc_start) s++;
        end
        chk("no_start_in_wait", s, 0);
        chk("overrun_after_drop", bus.overrun, OVR);
        delay = 2;
        wait_start("p4b", 50, t);
        chk("period_after_drop", t - t0, 20);
        load(10, 2);
        @(negedge clk);
        chk("overrun_cleared", bus.overrun, 0);

        @(negedge clk);
        delay = 8;
        abort = 1'b1;
        wait_start("p5a", 50, ts);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_step = 0;
        v = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.sample_valid) v++;
        end
        chk("no_valid_after_rst", v, 0);
        chk("step_after_rst", bus.step_idx, 0);
        abort = 1'b0;
        delay = 6;
        wait_start("p5b", 5000, t);
        chk("period_after_rst", t - ts, 4003);

        @(negedge clk);
        bus.enable = 1'b0;
        v = 0;
        s = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.sample_valid) v++;
            if (bus.adc_start) s++;
        end
        chk("valid_after_disable", v, 1);
        chk("no_start_disabled", s, 0);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
